cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 153 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues results from the ALU and the load/store unit
// in two per-source FIFOs and broadcasts at most one result per cycle on the CDB,
// using round-robin arbitration between the sources.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 synchronous clear of all queued and in-flight results
//   alu_valid/tag/name/data, alu_ready   ALU result offer and FIFO-not-full
//   ls_valid/tag/name/data,  ls_ready    load/store result offer and FIFO-not-full
//   cdb_en/tag/name/data  registered broadcast (tag/name/data hold when cdb_en=0)
module cdb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned NAME_W = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [NAME_W-1:0] alu_name,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ls_valid,
    input  logic [TAG_W-1:0]  ls_tag,
    input  logic [NAME_W-1:0] ls_name,
    input  logic [DATA_W-1:0] ls_data,
    output logic              ls_ready,
    output logic              cdb_en,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [NAME_W-1:0] cdb_name,
    output logic [DATA_W-1:0] cdb_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = TAG_W + NAME_W + DATA_W;

    // last_grant encoding: 0 = ALU, 1 = LS
    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_LS  = 1'b1;

    logic [ENT_W-1:0]  alu_mem_q [DEPTH];
    logic [ENT_W-1:0]  ls_mem_q  [DEPTH];

    logic [PTR_W-1:0]  alu_wptr_q, alu_wptr_d, alu_rptr_q, alu_rptr_d;
    logic [PTR_W-1:0]  ls_wptr_q,  ls_wptr_d,  ls_rptr_q,  ls_rptr_d;
    logic [CNT_W-1:0]  alu_cnt_q,  alu_cnt_d,  ls_cnt_q,   ls_cnt_d;
    logic              last_grant_q, last_grant_d;

    logic              cdb_en_q,   cdb_en_d;
    logic [TAG_W-1:0]  cdb_tag_q,  cdb_tag_d;
    logic [NAME_W-1:0] cdb_name_q, cdb_name_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

    logic              alu_push, ls_push, alu_pop, ls_pop;
    logic              alu_nempty, ls_nempty, grant_alu;
    logic [ENT_W-1:0]  head_sel;

    // Ready depends on the current count only, so a same-cycle pop never frees a full FIFO
    assign alu_ready = (alu_cnt_q != CNT_W'(DEPTH));
    assign ls_ready  = (ls_cnt_q  != CNT_W'(DEPTH));

    assign cdb_en   = cdb_en_q;
    assign cdb_tag  = cdb_tag_q;
    assign cdb_name = cdb_name_q;
    assign cdb_data = cdb_data_q;

    // Push/pop qualification, round-robin grant and next-state
    always_comb begin
        alu_push     = alu_valid && alu_ready && (alu_tag != '0) && !flush;
        ls_push      = ls_valid  && ls_ready  && (ls_tag  != '0) && !flush;
        alu_nempty   = (alu_cnt_q != '0);
        ls_nempty    = (ls_cnt_q  != '0);
        // Both pending: favour the source that did not win last time
        grant_alu    = alu_nempty && (!ls_nempty || (last_grant_q == GRANT_LS));
        alu_pop      = grant_alu && !flush;
        ls_pop       = ls_nempty && !grant_alu && !flush;

        alu_wptr_d   = alu_wptr_q;
        alu_rptr_d   = alu_rptr_q;
        alu_cnt_d    = alu_cnt_q;
        ls_wptr_d    = ls_wptr_q;
        ls_rptr_d    = ls_rptr_q;
        ls_cnt_d     = ls_cnt_q;
        last_grant_d = last_grant_q;
        cdb_en_d     = 1'b0;
        cdb_tag_d    = cdb_tag_q;
        cdb_name_d   = cdb_name_q;
        cdb_data_d   = cdb_data_q;
        head_sel     = ls_pop ? ls_mem_q[ls_rptr_q] : alu_mem_q[alu_rptr_q];

        if (flush) begin
            alu_wptr_d = '0;
            alu_rptr_d = '0;
            alu_cnt_d  = '0;
            ls_wptr_d  = '0;
            ls_rptr_d  = '0;
            ls_cnt_d   = '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two
            if (alu_push) alu_wptr_d = alu_wptr_q + PTR_W'(1);
            if (alu_pop)  alu_rptr_d = alu_rptr_q + PTR_W'(1);
            if (ls_push)  ls_wptr_d  = ls_wptr_q  + PTR_W'(1);
            if (ls_pop)   ls_rptr_d  = ls_rptr_q  + PTR_W'(1);
            alu_cnt_d = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(alu_pop);
            ls_cnt_d  = ls_cnt_q  + CNT_W'(ls_push)  - CNT_W'(ls_pop);

            if (alu_pop || ls_pop) begin
                cdb_en_d     = 1'b1;
                last_grant_d = ls_pop ? GRANT_LS : GRANT_ALU;
                {cdb_tag_d, cdb_name_d, cdb_data_d} = head_sel;
            end
        end
    end

    // Control and broadcast registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_wptr_q   <= '0;
            alu_rptr_q   <= '0;
            alu_cnt_q    <= '0;
            ls_wptr_q    <= '0;
            ls_rptr_q    <= '0;
            ls_cnt_q     <= '0;
            last_grant_q <= GRANT_LS;
            cdb_en_q     <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_name_q   <= '0;
            cdb_data_q   <= '0;
        end else begin
            alu_wptr_q   <= alu_wptr_d;
            alu_rptr_q   <= alu_rptr_d;
            alu_cnt_q    <= alu_cnt_d;
            ls_wptr_q    <= ls_wptr_d;
            ls_rptr_q    <= ls_rptr_d;
            ls_cnt_q     <= ls_cnt_d;
            last_grant_q <= last_grant_d;
            cdb_en_q     <= cdb_en_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_name_q   <= cdb_name_d;
            cdb_data_q   <= cdb_data_d;
        end
    end

    // FIFO storage; contents are don't-care while the count is zero
    always_ff @(posedge clk) begin
        if (alu_push) alu_mem_q[alu_wptr_q] <= {alu_tag, alu_name, alu_data};
        if (ls_push)  ls_mem_q[ls_wptr_q]   <= {ls_tag, ls_name, ls_data};
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned NAME_W = 5;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ENT_W  = TAG_W + NAME_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              alu_valid = 1'b0;
    logic [TAG_W-1:0]  alu_tag = '0;
    logic [NAME_W-1:0] alu_name = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              alu_ready;
    logic              ls_valid = 1'b0;
    logic [TAG_W-1:0]  ls_tag = '0;
    logic [NAME_W-1:0] ls_name = '0;
    logic [DATA_W-1:0] ls_data = '0;
    logic              ls_ready;
    logic              cdb_en;
    logic [TAG_W-1:0]  cdb_tag;
    logic [NAME_W-1:0] cdb_name;
    logic [DATA_W-1:0] cdb_data;

    int checks = 0;
    int failures = 0;

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NAME_W(NAME_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_name(alu_name),
        .alu_data(alu_data), .alu_ready(alu_ready),
        .ls_valid(ls_valid), .ls_tag(ls_tag), .ls_name(ls_name),
        .ls_data(ls_data), .ls_ready(ls_ready),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_name(cdb_name), .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: two queues of {tag,name,data} and a round-robin pointer
    logic [ENT_W-1:0]  qa[$];
    logic [ENT_W-1:0]  ql[$];
    logic              m_last;   // 1 = LS won last
    logic              m_en;
    logic [TAG_W-1:0]  m_tag;
    logic [NAME_W-1:0] m_name;
    logic [DATA_W-1:0] m_data;
    logic [ENT_W-1:0]  m_ent;
    logic              m_ra, m_rl;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
            ql.delete();
            m_last = 1'b1;
            m_en   = 1'b0;
            m_tag  = '0;
            m_name = '0;
            m_data = '0;
        end else begin
            m_ra = (qa.size() < DEPTH);
            m_rl = (ql.size() < DEPTH);
            if (flush) begin
                qa.delete();
                ql.delete();
                m_en = 1'b0;
            end else begin
                m_en = 1'b0;
                if (qa.size() > 0 && (ql.size() == 0 || m_last)) begin
                    m_ent = qa.pop_front();
                    m_en = 1'b1;
                    m_last = 1'b0;
                    {m_tag, m_name, m_data} = m_ent;
                end else if (ql.size() > 0) begin
                    m_ent = ql.pop_front();
                    m_en = 1'b1;
                    m_last = 1'b1;
                    {m_tag, m_name, m_data} = m_ent;
                end
                if (alu_valid && m_ra && alu_tag != 0) qa.push_back({alu_tag, alu_name, alu_data});
                if (ls_valid && m_rl && ls_tag != 0)   ql.push_back({ls_tag, ls_name, ls_data});
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_cdb_en",    64'(cdb_en),    64'(m_en));
            chk("m_cdb_tag",   64'(cdb_tag),   64'(m_tag));
            chk("m_cdb_name",  64'(cdb_name),  64'(m_name));
            chk("m_cdb_data",  64'(cdb_data),  64'(m_data));
            chk("m_alu_ready", 64'(alu_ready), 64'(qa.size() < DEPTH));
            chk("m_ls_ready",  64'(ls_ready),  64'(ql.size() < DEPTH));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        ls_valid  = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic offer_alu(input int t);
        alu_valid = 1'b1;
        alu_tag   = TAG_W'(t);
        alu_name  = NAME_W'(t + 16);
        alu_data  = 32'hA000_0000 + DATA_W'(t);
    endtask

    task automatic offer_ls(input int t);
        ls_valid = 1'b1;
        ls_tag   = TAG_W'(t);
        ls_name  = NAME_W'(t);
        ls_data  = 32'h5000_0000 + DATA_W'(t);
    endtask

    task automatic sync_reset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    logic [TAG_W-1:0] seen [4];
    logic [TAG_W-1:0] want [4];
    int nt;
    logic acc;

    initial begin
        want[0] = 4'd1; want[1] = 4'd5; want[2] = 4'd2; want[3] = 4'd6;
        // Reset with an ALU offer held across edges: nothing may be enqueued
        #1 rst = 1'b1;
        offer_alu(9);
        @(negedge clk);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        chk("rst_ls_ready",  64'(ls_ready),  64'd1);
        cyc();
        cyc();
        idle();
        rst = 1'b0;
        chk("rst_en",   64'(cdb_en),   64'd0);
        chk("rst_tag",  64'(cdb_tag),  64'd0);
        chk("rst_data", 64'(cdb_data), 64'd0);
        cyc();
        chk("rst_no_enq", 64'(cdb_en), 64'd0);

        // Single result latency
        alu_valid = 1'b1; alu_tag = 4'd3; alu_name = 5'd7; alu_data = 32'hDEADBEEF;
        cyc();
        idle();
        chk("single_not_yet", 64'(cdb_en), 64'd0);
        cyc();
        chk("single_en",   64'(cdb_en),   64'd1);
        chk("single_tag",  64'(cdb_tag),  64'd3);
        chk("single_name", 64'(cdb_name), 64'd7);
        chk("single_data", 64'(cdb_data), 64'hDEADBEEF);
        cyc();
        chk("single_one_cycle", 64'(cdb_en), 64'd0);
        chk("single_hold_tag",  64'(cdb_tag), 64'd3);

        // Contention after reset: order 1,5,2,6 with no gaps
        sync_reset();
        offer_alu(1); offer_ls(5);
        cyc();
        offer_alu(2); offer_ls(6);
        cyc();
        idle();
        for (int i = 0; i < 4; i++) begin
            chk("cont_en", 64'(cdb_en), 64'd1);
            seen[i] = cdb_tag;
            if (i < 3) cyc();
        end
        for (int i = 0; i < 4; i++) chk("cont_order", 64'(seen[i]), 64'(want[i]));
        cyc();
        chk("cont_done", 64'(cdb_en), 64'd0);

        // Free tag on LS is dropped
        offer_ls(0);
        cyc();
        idle();
        chk("free_tag_0", 64'(cdb_en), 64'd0);
        cyc();
        chk("free_tag_1", 64'(cdb_en), 64'd0);

        // Fill the ALU FIFO under contention until it reports full
        sync_reset();
        nt = 1;
        for (int i = 0; i < 7; i++) begin
            acc = alu_ready;
            offer_alu(nt);
            offer_ls(8);
            cyc();
            if (acc) nt++;
        end
        chk("full_alu_ready_low", 64'(alu_ready), 64'd0);
        offer_alu(nt);
        cyc();
        chk("full_ready_after_pop", 64'(alu_ready), 64'd1);
        idle();
        for (int i = 0; i < 12; i++) cyc();
        chk("full_drained", 64'(cdb_en), 64'd0);

        // Flush with three results queued; last_grant (ALU) must survive it
        sync_reset();
        offer_alu(1); offer_ls(5);
        cyc();
        offer_alu(2); offer_ls(6);
        cyc();
        idle();
        offer_alu(7);
        flush = 1'b1;
        cyc();
        idle();
        chk("flush_en",        64'(cdb_en),    64'd0);
        chk("flush_alu_ready", 64'(alu_ready), 64'd1);
        chk("flush_ls_ready",  64'(ls_ready),  64'd1);
        cyc();
        chk("flush_stays_0", 64'(cdb_en), 64'd0);
        offer_alu(3); offer_ls(4);
        cyc();
        idle();
        cyc();
        chk("flush_rr_first", 64'(cdb_tag), 64'd4);
        cyc();
        chk("flush_rr_second", 64'(cdb_tag), 64'd3);
        cyc();

        // Asynchronous reset pulse between edges while broadcasting
        for (int i = 0; i < 4; i++) begin
            offer_alu(i + 1); offer_ls(i + 9);
            cyc();
        end
        idle();
        chk("areset_pre_en", 64'(cdb_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("areset_en",        64'(cdb_en),    64'd0);
        chk("areset_tag",       64'(cdb_tag),   64'd0);
        chk("areset_alu_ready", 64'(alu_ready), 64'd1);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("areset_no_stale_0", 64'(cdb_en), 64'd0);
        cyc();
        chk("areset_no_stale_1", 64'(cdb_en), 64'd0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
